// File: rtl/bit_reverse_mapper_core.sv
// Registered bit-reversal permutation stage for the radix-2 FFT datapath.
// Output lane k carries input lane bitrev_N(k); one cycle latency, no backpressure.
module bit_reverse_mapper_core #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [(1<<N)*W-1:0]   in,
  output logic                  out_valid,
  output logic [(1<<N)*W-1:0]   out
);

  localparam int SIZE = 1 << N;

  // Reverse the N least-significant bits of a lane index (elaboration-time only).
  function automatic int bitrev(input int k);
    int r;
    r = 0;
    for (int j = 0; j < N; j++) begin
      if (((k >> j) & 1) != 0) begin
        r = r | (1 << (N - 1 - j));
      end
    end
    return r;
  endfunction

  logic [SIZE*W-1:0] perm_s;

  // Constant-index wiring network: no muxes, just lane relabelling.
  for (genvar k = 0; k < SIZE; k++) begin : g_lane
    localparam int SRC = bitrev(k);
    assign perm_s[k*W +: W] = in[SRC*W +: W];
  end

  // Output register: loads only on valid frames; reset clears frame and strobe at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= {(SIZE*W){1'b0}};
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= perm_s;
      end else begin
        out <= out;
      end
    end
  end

endmodule

// File: tb/tb_bit_reverse_mapper_core.sv
// Directed self-checking bench for bit_reverse_mapper_core (N=4 and N=3 instances).
module tb_bit_reverse_mapper_core;

  logic         clk;
  logic         rst;
  logic         in_valid_a, out_valid_a;
  logic [511:0] in_a, out_a;
  logic         in_valid_b, out_valid_b;
  logic [255:0] in_b, out_b;

  int tests;
  int fails;

  // Hand-computed 4-bit reversal table.
  int tbl4 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  logic [511:0] f0, f1, f2, f3, exp_a, hold_a;
  logic [255:0] exp_b;

  bit_reverse_mapper_core #(.N(4), .W(32)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in(in_a),
    .out_valid(out_valid_a), .out(out_a)
  );

  bit_reverse_mapper_core #(.N(3), .W(32)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in(in_b),
    .out_valid(out_valid_b), .out(out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_frame(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] perm4(input logic [511:0] f);
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = f[tbl4[k]*32 +: 32];
    return r;
  endfunction

  function automatic logic [511:0] rand_frame();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    in_a = '0; in_b = '0;
    #2;
    chk_frame("reset_out", out_a, 512'd0);
    chk_bit("reset_valid", out_valid_a, 1'b0);
    step();
    rst = 1'b0;
    step();

    // Index ramp, N=4
    for (int i = 0; i < 16; i++) in_a[i*32 +: 32] = i;
    exp_a = {32'd15, 32'd7, 32'd11, 32'd3, 32'd13, 32'd5, 32'd9, 32'd1,
             32'd14, 32'd6, 32'd10, 32'd2, 32'd12, 32'd4, 32'd8, 32'd0};
    in_valid_a = 1'b1;
    // Ramp, N=3
    for (int i = 0; i < 8; i++) in_b[i*32 +: 32] = 100 + i;
    exp_b = {32'd107, 32'd103, 32'd105, 32'd101, 32'd106, 32'd102, 32'd104, 32'd100};
    in_valid_b = 1'b1;
    step();
    chk_bit("ramp_valid", out_valid_a, 1'b1);
    chk_frame("ramp_data", out_a, exp_a);
    chk_bit("n3_valid", out_valid_b, 1'b1);
    chk_frame("n3_data", {256'd0, out_b}, {256'd0, exp_b});
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    in_a = rand_frame();
    step();
    chk_bit("ramp_after_valid", out_valid_a, 1'b0);
    chk_frame("ramp_after_hold", out_a, exp_a);

    // Involution with random data
    f0 = rand_frame();
    in_a = f0; in_valid_a = 1'b1;
    step();
    chk_frame("invol_first", out_a, perm4(f0));
    in_a = out_a;
    step();
    chk_frame("invol_second", out_a, f0);

    // All-ones and A5 pattern mix
    for (int i = 0; i < 16; i++) f1[i*32 +: 32] = (i % 3 == 0) ? 32'hFFFF_FFFF : 32'hA5A5_A5A5;
    in_a = f1;
    step();
    chk_frame("pattern_mix", out_a, perm4(f1));
    in_a = {16{32'hFFFF_FFFF}};
    step();
    chk_frame("all_ones", out_a, {16{32'hFFFF_FFFF}});
    in_valid_a = 1'b0;
    step();

    // Streaming: three back-to-back frames
    f1 = rand_frame(); f2 = rand_frame(); f3 = rand_frame();
    in_valid_a = 1'b1;
    in_a = f1; step();
    chk_bit("stream_v1", out_valid_a, 1'b1);
    chk_frame("stream_d1", out_a, perm4(f1));
    in_a = f2; step();
    chk_bit("stream_v2", out_valid_a, 1'b1);
    chk_frame("stream_d2", out_a, perm4(f2));
    in_a = f3; step();
    chk_bit("stream_v3", out_valid_a, 1'b1);
    chk_frame("stream_d3", out_a, perm4(f3));
    in_valid_a = 1'b0; in_a = rand_frame(); step();
    chk_bit("stream_end_valid", out_valid_a, 1'b0);
    chk_frame("stream_end_hold", out_a, perm4(f3));

    // Asynchronous reset mid-cycle
    f0 = rand_frame();
    in_a = f0; in_valid_a = 1'b1;
    step();
    chk_frame("arst_loaded", out_a, perm4(f0));
    #2;
    rst = 1'b1;
    in_a = rand_frame();
    #1;
    chk_frame("arst_out_zero", out_a, 512'd0);
    chk_bit("arst_valid_zero", out_valid_a, 1'b0);
    step();
    step();
    chk_frame("arst_ignore_data", out_a, 512'd0);
    chk_bit("arst_ignore_valid", out_valid_a, 1'b0);
    #2;
    rst = 1'b0;
    in_valid_a = 1'b0;
    step();
    chk_bit("arst_rel_idle", out_valid_a, 1'b0);
    f1 = rand_frame();
    in_a = f1; in_valid_a = 1'b1;
    step();
    chk_bit("arst_first_valid", out_valid_a, 1'b1);
    chk_frame("arst_first_data", out_a, perm4(f1));

    // Hold for 5 idle cycles with random input
    f2 = rand_frame();
    in_a = f2;
    step();
    hold_a = perm4(f2);
    in_valid_a = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_a = rand_frame();
      step();
      chk_bit("hold_valid", out_valid_a, 1'b0);
      chk_frame("hold_data", out_a, hold_a);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bit_reverse_mapper_core.md
# bit_reverse_mapper_core

Registered bit-reversal permutation stage for the radix-2 FFT datapath. Accepts one frame of 2^N complex samples in parallel and reorders it so that output lane k carries input lane bitrev_N(k). The block sits between sample capture and the first butterfly stage. The permutation is pure wiring, but the result is registered for timing closure and qualified by a valid strobe.

## Interface
- N, default 4: address width in bits; frame size SIZE = 2^N lanes. Legal range 1..8.
- W, default 32: lane width in bits, carrying a packed complex sample (opaque to this block).
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  marks a frame on `in` this cycle.
- in  input  SIZE*W  flattened input frame; lane k occupies bits [k*W+W-1 : k*W].
- out_valid  output  1  marks a valid reordered frame on `out`.
- out  output  SIZE*W  flattened output frame, using the same lane packing as `in`.

## Operation
- bitrev_N(k): reverse the N least-significant bits of lane index k, so bit j of k moves to bit N-1-j.
  - N=4 examples: 1→8, 2→4, 3→12, 5→10, 7→14, 0→0, 15→15.
- Lane mapping is out lane k = in lane bitrev_N(k), for all k in 0..SIZE-1.
- Data is passed bit-exact; no arithmetic, sign handling or width change.
- The permutation is an involution, so applying the block twice restores the original order.
- Palindromic indices map to themselves, e.g. 0, 6, 9, 15 when N=4.
- The reversal network is a generate loop of constant index wiring; no muxes, no state machine.
- Capture rule:
  - When in_valid=1 at a rising clk edge, the permuted frame is loaded into the output register.
  - When in_valid=0, the output register holds its previous contents.
- Ready handling: there is no backpressure. The block is always ready and accepts one frame per cycle.

## Timing
- Latency is exactly 1 cycle.
- out_valid is a registered copy of in_valid: out_valid(t+1) = in_valid(t).
- `out` updates only on edges where in_valid=1, and is stable otherwise.
- Back-to-back frames on consecutive cycles produce consecutive valid outputs with no bubbles.
- Reset:
  - Asserting rst immediately, without waiting for a clock edge, drives out to all zeros and out_valid to 0.
  - While rst=1, in_valid is ignored.
  - The first capture after release occurs at the first rising edge with rst=0 and in_valid=1.
  - Reset asserted mid-stream discards the pending frame. No partial frame is ever emitted.
- There are no combinational paths from inputs to outputs.

## Test plan
- Index ramp, N=4, W=32: set in lane i = i, pulse in_valid for 1 cycle.
  - Next cycle: out_valid=1 and out lanes = 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
  - The cycle after: out_valid=0 and out unchanged.
- 8-point configuration, N=3: lanes i = 100+i, in_valid pulse.
  - out lanes = 100,104,102,106,101,105,103,107.
- Involution and data integrity, N=4: apply random 32-bit lanes, then feed `out` back as the next input frame.
  - Second output equals the original frame.
  - All-ones and 0xA5A5A5A5 patterns pass unchanged apart from their lane position.
- Streaming: present 3 distinct frames on consecutive cycles with in_valid held at 1.
  - out_valid is high for exactly 3 consecutive cycles.
  - Each output frame is the permutation of its own input, in order.
- Asynchronous reset: after a valid frame is loaded, assert rst between clock edges.
  - out becomes 0 and out_valid becomes 0 before the next edge.
  - With in_valid=1 during reset, nothing is captured.
  - After rst drops, the first valid frame appears one cycle after its in_valid.
- Hold: load one frame, then run 5 cycles with in_valid=0 and random data on `in`.
  - out stays at the loaded values and out_valid stays 0.
